key_note_scheduler: RTL and testbench

KEY_NOTE_SCHEDULER -- requirements
Module: key_note_scheduler

---
 rtl/key_note_scheduler.sv | 251 +++++++++++++++++++++++++
 tb/tb_key_note_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_note_scheduler.sv
// Key/note scheduler: turns a held-key bitmap or a built-in song into a
// registered tone half-period, with last-pressed-wins key arbitration.
module key_note_scheduler #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned UNIT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  key_req,
    input  logic        play_start,
    input  logic        play_stop,
    output logic [25:0] note,
    output logic        note_on,
    output logic [2:0]  active_key,
    output logic        busy
);

    // One counter times both note durations (up to 15 units) and gaps.
    localparam int unsigned DUR_MAX = 15 * UNIT_CYCLES;
    localparam int unsigned CNT_MAX = (DUR_MAX > GAP_CYCLES) ? DUR_MAX : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // The note table holds half-periods for a 100 MHz clock; this block
    // exists only to flag builds configured for a different clock.
    if (CLK_HZ != 100_000_000) begin : g_note_table_not_scaled
    end

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        PLAY,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         prev_key_q;

    logic [25:0]        note_q, note_d;
    logic               note_on_q, note_on_d;
    logic [2:0]         active_key_q, active_key_d;
    logic               busy_q, busy_d;

    logic [7:0]         rise;
    logic [2:0]         arb_key;
    logic               key_any;

    logic [7:0]         cur_entry;
    logic [7:0]         nxt_entry;
    logic [7:0]         first_entry;
    logic [7:0]         play_entry;
    logic [3:0]         nxt_idx;
    logic [CNT_W-1:0]   dur_cycles;

    // Half-period counts for C4..C5 at 100 MHz.
    function automatic logic [25:0] note_of(input logic [2:0] k);
        logic [25:0] n;
        case (k)
            3'd0:    n = 26'd191109;
            3'd1:    n = 26'd170264;
            3'd2:    n = 26'd151685;
            3'd3:    n = 26'd143172;
            3'd4:    n = 26'd127550;
            3'd5:    n = 26'd113635;
            3'd6:    n = 26'd101239;
            default: n = 26'd95555;
        endcase
        return n;
    endfunction

    // Song ROM entry = {rest, key[2:0], dur[3:0]}; dur==0 marks the end.
    function automatic logic [7:0] rom_entry(input logic [3:0] idx);
        logic [7:0] e;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: e = {1'b0, idx[2:0], 4'd2};
            default:                e = 8'h00;
        endcase
        return e;
    endfunction

    assign key_any     = |key_req;
    assign cur_entry   = rom_entry(idx_q);
    assign nxt_idx     = idx_q + 4'd1;
    assign nxt_entry   = rom_entry(nxt_idx);
    assign first_entry = rom_entry(4'd0);
    assign dur_cycles  = CNT_W'(cur_entry[3:0]) * CNT_W'(UNIT_CYCLES);
    assign play_entry  = rom_entry(idx_d);

    // Manual arbitration: newest rising key wins (lowest index on ties),
    // otherwise keep the sounding key, otherwise the lowest held key.
    always_comb begin
        logic       rise_found;
        logic       held_found;
        logic [2:0] rise_key;
        logic [2:0] held_key;
        rise       = key_req & ~prev_key_q;
        rise_found = 1'b0;
        held_found = 1'b0;
        rise_key   = '0;
        held_key   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!rise_found && rise[3'(i)]) begin
                rise_found = 1'b1;
                rise_key   = 3'(i);
            end
            if (!held_found && key_req[3'(i)]) begin
                held_found = 1'b1;
                held_key   = 3'(i);
            end
        end
        if (rise_found) begin
            arb_key = rise_key;
        end else if (state_q == MANUAL && key_req[active_key_q]) begin
            arb_key = active_key_q;
        end else begin
            arb_key = held_key;
        end
    end

    // State, song position, timing counter and key history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            prev_key_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            prev_key_q <= key_req;
        end
    end

    // Next-state: stop beats keys beats start; song advances through GAP.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (key_any) begin
                    state_d = MANUAL;
                end else if (play_start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (first_entry[3:0] == 4'd0) ? IDLE : PLAY;
                end
            end
            MANUAL: begin
                if (!key_any) begin
                    state_d = IDLE;
                end
            end
            PLAY, GAP: begin
                if (play_stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (key_any) begin
                    state_d = MANUAL;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (play_start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = (first_entry[3:0] == 4'd0) ? IDLE : PLAY;
                end else if (state_q == PLAY) begin
                    if (cnt_q == dur_cycles - CNT_W'(1)) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_d = '0;
                        // Wrap past entry 15 or an end marker ends the song.
                        if (idx_q == 4'd15 || nxt_entry[3:0] == 4'd0) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            state_d = PLAY;
                            idx_d   = nxt_idx;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the state being entered, registered below.
    always_comb begin
        note_d       = '0;
        note_on_d    = 1'b0;
        active_key_d = '0;
        busy_d       = 1'b0;
        case (state_d)
            MANUAL: begin
                note_d       = note_of(arb_key);
                note_on_d    = 1'b1;
                active_key_d = arb_key;
            end
            PLAY: begin
                busy_d = 1'b1;
                if (!play_entry[7]) begin
                    note_d       = note_of(play_entry[6:4]);
                    note_on_d    = 1'b1;
                    active_key_d = play_entry[6:4];
                end
            end
            GAP: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_q       <= '0;
            note_on_q    <= 1'b0;
            active_key_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            note_q       <= note_d;
            note_on_q    <= note_on_d;
            active_key_q <= active_key_d;
            busy_q       <= busy_d;
        end
    end

    assign note       = note_q;
    assign note_on    = note_on_q;
    assign active_key = active_key_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_key_note_scheduler.sv
// Bench for key_note_scheduler: directed scenarios then random keys and
// play pulses, compared every cycle against a song-time reference model.
module tb_key_note_scheduler;

    localparam int unsigned UNIT = 10;
    localparam int unsigned GAPC = 2;
    localparam int unsigned SLOT = 2 * UNIT + GAPC;   // cycles per song note
    localparam int unsigned SONG = 8 * SLOT;          // cycles the song lasts

    logic        clk;
    logic        reset;
    logic [7:0]  key_req;
    logic        play_start;
    logic        play_stop;
    logic [25:0] note;
    logic        note_on;
    logic [2:0]  active_key;
    logic        busy;

    int unsigned n_cmp;
    int unsigned n_mis;

    int unsigned NOTES [8] = '{191109, 170264, 151685, 143172,
                               127550, 113635, 101239, 95555};

    // Reference model: 0 = silent, 1 = keys, 2 = song; m_t = cycles into song.
    int unsigned m_mode;
    int unsigned m_t;
    int unsigned m_act;
    logic [7:0]  m_prev;

    key_note_scheduler #(
        .CLK_HZ      (100_000_000),
        .UNIT_CYCLES (UNIT),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_req    (key_req),
        .play_start (play_start),
        .play_stop  (play_stop),
        .note       (note),
        .note_on    (note_on),
        .active_key (active_key),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    function automatic int unsigned lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_t    = 0;
        m_act  = 0;
        m_prev = '0;
    endtask

    task automatic model_step();
        logic [7:0] rises;
        if (reset) begin
            model_reset();
            return;
        end
        rises = key_req & ~m_prev;
        if (m_mode == 1) begin
            if (key_req == 0) m_mode = 0;
            else if (rises != 0) m_act = lowest(rises);
            else if (!key_req[3'(m_act)]) m_act = lowest(key_req);
        end else if (m_mode == 2) begin
            if (play_stop) begin
                m_mode = 0;
            end else if (key_req != 0) begin
                m_mode = 1;
                m_act  = (rises != 0) ? lowest(rises) : lowest(key_req);
            end else if (play_start) begin
                m_t = 0;
            end else begin
                m_t++;
                if (m_t >= SONG) m_mode = 0;
            end
        end else begin
            if (key_req != 0) begin
                m_mode = 1;
                m_act  = (rises != 0) ? lowest(rises) : lowest(key_req);
            end else if (play_start) begin
                m_mode = 2;
                m_t    = 0;
            end
        end
        m_prev = key_req;
    endtask

    task automatic check_all();
        int unsigned e_note, e_on, e_act, e_busy;
        e_note = 0; e_on = 0; e_act = 0; e_busy = 0;
        if (m_mode == 1) begin
            e_note = NOTES[m_act];
            e_on   = 1;
            e_act  = m_act;
        end else if (m_mode == 2) begin
            e_busy = 1;
            if ((m_t % SLOT) < 2 * UNIT) begin
                e_note = NOTES[m_t / SLOT];
                e_on   = 1;
                e_act  = m_t / SLOT;
            end
        end
        chk("note", 32'(note), e_note);
        chk("note_on", 32'(note_on), e_on);
        chk("active_key", 32'(active_key), e_act);
        chk("busy", 32'(busy), e_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic async_reset_check();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        int unsigned busy_cnt;
        n_cmp = 0;
        n_mis = 0;
        model_reset();
        reset = 1'b1; key_req = '0; play_start = 1'b0; play_stop = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single key press and release.
        key_req = 8'h04; tick();
        chk("k2_note", 32'(note), 32'd151685);
        chk("k2_act", 32'(active_key), 32'd2);
        key_req = 8'h00; tick();
        chk("rel_on", 32'(note_on), 32'd0);

        // Last pressed wins, release falls back to lowest held.
        key_req = 8'h01; tick();
        key_req = 8'h81; tick();
        chk("k7_act", 32'(active_key), 32'd7);
        chk("k7_note", 32'(note), 32'd95555);
        key_req = 8'h01; tick();
        chk("back_act", 32'(active_key), 32'd0);
        chk("back_note", 32'(note), 32'd191109);
        key_req = 8'h00; tick();

        // Simultaneous rises pick the lowest index.
        key_req = 8'h28; tick();
        chk("multi_act", 32'(active_key), 32'd3);
        chk("multi_note", 32'(note), 32'd143172);
        key_req = 8'h00; tick();

        // Whole song: busy for 8 slots, then idle.
        play_start = 1'b1; tick();
        play_start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < SONG + 4; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("song_len", busy_cnt, SONG);

        // Stop beats start; a key press aborts the song.
        play_start = 1'b1; tick();
        play_start = 1'b0;
        repeat (30) tick();
        play_start = 1'b1; play_stop = 1'b1; tick();
        play_start = 1'b0; play_stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        play_start = 1'b1; tick();
        play_start = 1'b0;
        repeat (25) tick();
        key_req = 8'h02; tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_act", 32'(active_key), 32'd1);
        key_req = 8'h00; tick();

        // Asynchronous reset mid-song; keys held through reset count as new.
        play_start = 1'b1; tick();
        play_start = 1'b0;
        repeat (5) tick();
        async_reset_check();
        chk("rst_note", 32'(note), 32'd0);
        key_req = 8'h10;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_key_act", 32'(active_key), 32'd4);
        key_req = 8'h00;
        repeat (5) tick();
        chk("rst_idle", 32'(busy), 32'd0);
        play_start = 1'b1; tick();
        play_start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);

        // Random keys, play pulses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) begin
                key_req = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
            end
            play_start = ($urandom_range(39) == 0);
            play_stop  = ($urandom_range(59) == 0);
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(499) == 0) begin
                async_reset_check();
            end
            tick();
        end
        play_start = 1'b0; play_stop = 1'b0; key_req = '0; reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
